// File: rtl/pipe_control_unit.sv
// Pipelined LEGv8 control unit: decodes the IF/ID instruction, carries its
// control bits through ID/EX, EX/MEM and MEM/WB, and generates load-use
// stalls, taken-branch squashes and external-stall freezes.
module pipe_control_unit #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned ZERO_REG  = 31,
    parameter int unsigned LINK_REG  = 30,
    parameter int unsigned HAZARD_EN = 1,
    parameter int unsigned FLUSH_EX  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             id_valid,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic             id_reg2loc,
    output logic             ex_alusrc,
    output logic [1:0]       ex_aluop,
    output logic             ex_cb_instr,
    output logic [REG_W-1:0] ex_rd,
    output logic             mem_branch,
    output logic             mem_uncondbranch,
    output logic             mem_not_zero,
    output logic             mem_branchreg,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic [REG_W-1:0] mem_rd,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic             wb_branchlink,
    output logic [REG_W-1:0] wb_rd,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             illegal
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
    localparam logic [REG_W-1:0] LR = REG_W'(LINK_REG);

    typedef enum logic [3:0] {
        OP_NONE, OP_RTYPE, OP_ALUI, OP_LDUR, OP_STUR, OP_BR,
        OP_CBZ, OP_CBNZ, OP_BL, OP_B, OP_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             branchlink;
        logic [REG_W-1:0] rd;
    } wb_ctrl_t;

    typedef struct packed {
        logic     branch;
        logic     uncondbranch;
        logic     not_zero;
        logic     branchreg;
        logic     memread;
        logic     memwrite;
        wb_ctrl_t wb;
    } mem_ctrl_t;

    typedef struct packed {
        logic      alusrc;
        logic [1:0] aluop;
        logic      cb_instr;
        logic      illegal;
        mem_ctrl_t mem;
    } ex_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0, branchlink: 1'b0, rd: ZR};
    localparam mem_ctrl_t MEM_BUBBLE = '{branch: 1'b0, uncondbranch: 1'b0, not_zero: 1'b0,
                                         branchreg: 1'b0, memread: 1'b0, memwrite: 1'b0,
                                         wb: WB_BUBBLE};
    localparam ex_ctrl_t EX_BUBBLE = '{alusrc: 1'b0, aluop: 2'b00, cb_instr: 1'b0,
                                       illegal: 1'b0, mem: MEM_BUBBLE};

    op_class_e        op_class;
    ex_ctrl_t         id_ctrl;
    logic             reg2loc;
    logic             uses_rn;
    logic             uses_r2;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] r2;
    logic             load_use;
    ex_ctrl_t         id_ex;
    mem_ctrl_t        ex_mem;
    wb_ctrl_t         mem_wb;

    // Immediate/shamt field bits play no part in control decode.
    logic unused_bits;
    assign unused_bits = ^instr[15:10];

    // Classify the IF/ID opcode; invalid slots decode as nothing.
    always_comb begin
        op_class = OP_NONE;
        if (id_valid) begin
            casez (instr[31:21])
                11'b10001011000, 11'b11001011000, 11'b10001010000,
                11'b10101010000, 11'b11001010000:               op_class = OP_RTYPE;
                11'b1001000100?, 11'b1101000100?,
                11'b11010011011, 11'b11010011010:               op_class = OP_ALUI;
                11'b11111000010:                                op_class = OP_LDUR;
                11'b11111000000:                                op_class = OP_STUR;
                11'b11010110000:                                op_class = OP_BR;
                11'b10110100???:                                op_class = OP_CBZ;
                11'b10110101???:                                op_class = OP_CBNZ;
                11'b100101?????:                                op_class = OP_BL;
                11'b000101?????:                                op_class = OP_B;
                default:                                        op_class = OP_ILLEGAL;
            endcase
        end
    end

    // Expand the opcode class into control bits, destination and hazard sources.
    always_comb begin
        id_ctrl = EX_BUBBLE;
        reg2loc = 1'b0;
        uses_rn = 1'b0;
        uses_r2 = 1'b0;
        case (op_class)
            OP_RTYPE: begin
                id_ctrl.mem.wb.regwrite = 1'b1;
                id_ctrl.aluop           = 2'b10;
                uses_rn                 = 1'b1;
                uses_r2                 = 1'b1;
            end
            OP_ALUI: begin
                id_ctrl.alusrc          = 1'b1;
                id_ctrl.mem.wb.regwrite = 1'b1;
                id_ctrl.aluop           = 2'b10;
                uses_rn                 = 1'b1;
            end
            OP_LDUR: begin
                id_ctrl.alusrc          = 1'b1;
                id_ctrl.mem.wb.memtoreg = 1'b1;
                id_ctrl.mem.wb.regwrite = 1'b1;
                id_ctrl.mem.memread     = 1'b1;
                uses_rn                 = 1'b1;
            end
            OP_STUR: begin
                reg2loc              = 1'b1;
                id_ctrl.alusrc       = 1'b1;
                id_ctrl.mem.memwrite = 1'b1;
                uses_rn              = 1'b1;
                uses_r2              = 1'b1;
            end
            OP_BR: begin
                id_ctrl.mem.branchreg = 1'b1;
                uses_rn               = 1'b1;
            end
            OP_CBZ, OP_CBNZ: begin
                reg2loc              = 1'b1;
                id_ctrl.mem.branch   = 1'b1;
                id_ctrl.aluop        = 2'b01;
                id_ctrl.cb_instr     = 1'b1;
                id_ctrl.mem.not_zero = (op_class == OP_CBNZ);
                uses_r2              = 1'b1;
            end
            OP_BL: begin
                id_ctrl.mem.uncondbranch  = 1'b1;
                id_ctrl.mem.wb.branchlink = 1'b1;
                id_ctrl.mem.wb.regwrite   = 1'b1;
                id_ctrl.cb_instr          = 1'b1;
            end
            OP_B: begin
                id_ctrl.mem.uncondbranch = 1'b1;
                id_ctrl.cb_instr         = 1'b1;
            end
            OP_ILLEGAL: id_ctrl.illegal = 1'b1;
            default: ;
        endcase
        if (id_ctrl.mem.wb.branchlink) begin
            id_ctrl.mem.wb.rd = LR;
        end else if (id_ctrl.mem.wb.regwrite) begin
            id_ctrl.mem.wb.rd = REG_W'(instr[4:0]);
        end
    end

    assign id_reg2loc = reg2loc;
    assign rn         = REG_W'(instr[9:5]);
    assign r2         = reg2loc ? REG_W'(instr[4:0]) : REG_W'(instr[20:16]);

    assign load_use = (HAZARD_EN != 0) && id_ex.mem.memread && (id_ex.mem.wb.rd != ZR) &&
                      ((uses_rn && (rn == id_ex.mem.wb.rd)) ||
                       (uses_r2 && (r2 == id_ex.mem.wb.rd)));

    // PC / IF-ID enables follow reset > branch_taken > ext_stall > load_use.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        if (!reset) begin
            if (branch_taken) begin
                if_id_flush = 1'b1;
            end else if (ext_stall || load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
        end
    end

    // Pipeline control registers with bubble insertion, squash and freeze.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_ex  <= EX_BUBBLE;
            ex_mem <= MEM_BUBBLE;
            mem_wb <= WB_BUBBLE;
        end else if (branch_taken) begin
            id_ex  <= EX_BUBBLE;
            ex_mem <= (FLUSH_EX != 0) ? MEM_BUBBLE : id_ex.mem;
            mem_wb <= ex_mem.wb;
        end else if (!ext_stall) begin
            id_ex  <= load_use ? EX_BUBBLE : id_ctrl;
            ex_mem <= id_ex.mem;
            mem_wb <= ex_mem.wb;
        end
    end

    assign ex_alusrc        = id_ex.alusrc;
    assign ex_aluop         = id_ex.aluop;
    assign ex_cb_instr      = id_ex.cb_instr;
    assign ex_rd            = id_ex.mem.wb.rd;
    assign illegal          = id_ex.illegal;
    assign mem_branch       = ex_mem.branch;
    assign mem_uncondbranch = ex_mem.uncondbranch;
    assign mem_not_zero     = ex_mem.not_zero;
    assign mem_branchreg    = ex_mem.branchreg;
    assign mem_memread      = ex_mem.memread;
    assign mem_memwrite     = ex_mem.memwrite;
    assign mem_rd           = ex_mem.wb.rd;
    assign wb_regwrite      = mem_wb.regwrite;
    assign wb_memtoreg      = mem_wb.memtoreg;
    assign wb_branchlink    = mem_wb.branchlink;
    assign wb_rd            = mem_wb.rd;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: two instances (FLUSH_EX=1 and 0)
// share stimulus; a table-driven reference model predicts every output.
module tb_pipe_control_unit;

    localparam logic [4:0] ZR = 5'd31;
    localparam logic [4:0] LR = 5'd30;

    // flag order: reg2loc alusrc memtoreg regwrite memread memwrite branch aluop[1:0] uncond link brreg notzero cb
    localparam logic [13:0] F_R    = 14'b0_0_0_1_0_0_0_10_0_0_0_0_0;
    localparam logic [13:0] F_I    = 14'b0_1_0_1_0_0_0_10_0_0_0_0_0;
    localparam logic [13:0] F_LD   = 14'b0_1_1_1_1_0_0_00_0_0_0_0_0;
    localparam logic [13:0] F_ST   = 14'b1_1_0_0_0_1_0_00_0_0_0_0_0;
    localparam logic [13:0] F_BR   = 14'b0_0_0_0_0_0_0_00_0_0_1_0_0;
    localparam logic [13:0] F_CBZ  = 14'b1_0_0_0_0_0_1_01_0_0_0_0_1;
    localparam logic [13:0] F_CBNZ = 14'b1_0_0_0_0_0_1_01_0_0_0_1_1;
    localparam logic [13:0] F_BL   = 14'b0_0_0_1_0_0_0_00_1_1_0_0_1;
    localparam logic [13:0] F_B    = 14'b0_0_0_0_0_0_0_00_1_0_0_0_1;

    typedef struct {
        int          plen;
        logic [10:0] pat;
        logic [13:0] f;
        bit          urn;
        bit          ur2;
    } ent_t;

    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       cb;
        logic       branch, uncond, nz, brreg, memread, memwrite;
        logic       regwrite, memtoreg, link, illegal;
        logic [4:0] rd;
    } rec_t;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic [1:0] aluop;
        logic       cb;
        logic [4:0] ex_rd;
        logic       branch, uncond, nz, brreg, memread, memwrite;
        logic [4:0] mem_rd;
        logic       regwrite, memtoreg, link;
        logic [4:0] wb_rd;
        logic       pcw, ifw, flush, illegal;
    } obs_t;

    logic        clock = 1'b0;
    logic        reset, id_valid, branch_taken, ext_stall;
    logic [31:0] instr;
    obs_t        obs[2];

    ent_t tbl[16];
    rec_t m_ex[2], m_mem[2], m_wb[2];
    obs_t q0[$], q1[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic       r2l, als, cb, br, unc, nz, brr, mr, mw, rw, m2r, lnk, pcw, ifw, fl, ill;
        logic [1:0] aop;
        logic [4:0] erd, mrd, wrd;
        pipe_control_unit #(
            .REG_W(5), .ZERO_REG(31), .LINK_REG(30), .HAZARD_EN(1), .FLUSH_EX(gi == 0 ? 1 : 0)
        ) dut (
            .clock(clock), .reset(reset), .instr(instr), .id_valid(id_valid),
            .branch_taken(branch_taken), .ext_stall(ext_stall),
            .id_reg2loc(r2l), .ex_alusrc(als), .ex_aluop(aop), .ex_cb_instr(cb), .ex_rd(erd),
            .mem_branch(br), .mem_uncondbranch(unc), .mem_not_zero(nz), .mem_branchreg(brr),
            .mem_memread(mr), .mem_memwrite(mw), .mem_rd(mrd),
            .wb_regwrite(rw), .wb_memtoreg(m2r), .wb_branchlink(lnk), .wb_rd(wrd),
            .pc_write(pcw), .if_id_write(ifw), .if_id_flush(fl), .illegal(ill)
        );
        assign obs[gi] = '{reg2loc: r2l, alusrc: als, aluop: aop, cb: cb, ex_rd: erd,
                           branch: br, uncond: unc, nz: nz, brreg: brr, memread: mr,
                           memwrite: mw, mem_rd: mrd, regwrite: rw, memtoreg: m2r,
                           link: lnk, wb_rd: wrd, pcw: pcw, ifw: ifw, flush: fl, illegal: ill};
    end

    function automatic rec_t bubble();
        rec_t r = '0;
        r.rd = ZR;
        return r;
    endfunction

    // Opcode lookup: an entry matches when the top plen bits of the opcode equal its pattern.
    function automatic void ref_decode(input logic [31:0] ins, input bit v, output rec_t r,
                                       output bit r2l, output bit urn, output bit ur2);
        logic [10:0] op;
        logic [13:0] f;
        op  = ins[31:21];
        r   = bubble();
        r2l = 0; urn = 0; ur2 = 0;
        if (!v) return;
        for (int i = 0; i < 16; i++) begin
            if ((op >> (11 - tbl[i].plen)) == (tbl[i].pat >> (11 - tbl[i].plen))) begin
                f = tbl[i].f;
                r2l = f[13]; r.alusrc = f[12]; r.memtoreg = f[11]; r.regwrite = f[10];
                r.memread = f[9]; r.memwrite = f[8]; r.branch = f[7]; r.aluop = f[6:5];
                r.uncond = f[4]; r.link = f[3]; r.brreg = f[2]; r.nz = f[1]; r.cb = f[0];
                urn = tbl[i].urn; ur2 = tbl[i].ur2;
                r.rd = r.link ? LR : (r.regwrite ? ins[4:0] : ZR);
                return;
            end
        end
        r.illegal = 1'b1;
    endfunction

    function automatic obs_t make_exp(rec_t ex, rec_t mem, rec_t wb, bit r2l, bit pcw, bit ifw, bit fl);
        obs_t e;
        e.reg2loc = r2l; e.alusrc = ex.alusrc; e.aluop = ex.aluop; e.cb = ex.cb; e.ex_rd = ex.rd;
        e.illegal = ex.illegal;
        e.branch = mem.branch; e.uncond = mem.uncond; e.nz = mem.nz; e.brreg = mem.brreg;
        e.memread = mem.memread; e.memwrite = mem.memwrite; e.mem_rd = mem.rd;
        e.regwrite = wb.regwrite; e.memtoreg = wb.memtoreg; e.link = wb.link; e.wb_rd = wb.rd;
        e.pcw = pcw; e.ifw = ifw; e.flush = fl;
        return e;
    endfunction

    // One clock of stimulus: drive inputs, queue the expected outputs, advance the model.
    task automatic step(input logic [31:0] i, input bit v, input bit bt, input bit st,
                        input bit rs, input bit chk = 1'b1);
        rec_t d;
        bit   r2l, urn, ur2, lu, pcw, ifw, fl;
        logic [4:0] rn, r2;
        @(negedge clock);
        instr = i; id_valid = v; branch_taken = bt; ext_stall = st; reset = rs;
        #1;
        ref_decode(i, v, d, r2l, urn, ur2);
        rn = i[9:5];
        r2 = r2l ? i[4:0] : i[20:16];
        for (int m = 0; m < 2; m++) begin
            lu = m_ex[m].memread && (m_ex[m].rd != ZR) &&
                 ((urn && rn == m_ex[m].rd) || (ur2 && r2 == m_ex[m].rd));
            pcw = rs || bt || !(st || lu);
            ifw = pcw;
            fl  = !rs && bt;
            if (chk) begin
                if (m == 0) q0.push_back(make_exp(m_ex[m], m_mem[m], m_wb[m], r2l, pcw, ifw, fl));
                else        q1.push_back(make_exp(m_ex[m], m_mem[m], m_wb[m], r2l, pcw, ifw, fl));
            end
            if (rs) begin
                m_ex[m] = bubble(); m_mem[m] = bubble(); m_wb[m] = bubble();
            end else if (bt) begin
                m_wb[m]  = m_mem[m];
                m_mem[m] = (m == 0) ? bubble() : m_ex[m];
                m_ex[m]  = bubble();
            end else if (!st) begin
                m_wb[m]  = m_mem[m];
                m_mem[m] = m_ex[m];
                m_ex[m]  = lu ? bubble() : d;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic grp(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, m, $time, act, exp);
        end
    endtask

    task automatic compare(input int m, input obs_t e);
        obs_t a;
        a = obs[m];
        vectors++;
        grp("comb", m, 32'({a.reg2loc, a.pcw, a.ifw, a.flush}), 32'({e.reg2loc, e.pcw, e.ifw, e.flush}));
        grp("ex", m, 32'({a.alusrc, a.aluop, a.cb, a.ex_rd}), 32'({e.alusrc, e.aluop, e.cb, e.ex_rd}));
        grp("mem", m, 32'({a.branch, a.uncond, a.nz, a.brreg, a.memread, a.memwrite, a.mem_rd}),
                      32'({e.branch, e.uncond, e.nz, e.brreg, e.memread, e.memwrite, e.mem_rd}));
        grp("wb", m, 32'({a.regwrite, a.memtoreg, a.link, a.wb_rd}), 32'({e.regwrite, e.memtoreg, e.link, e.wb_rd}));
        grp("illegal", m, 32'(a.illegal), 32'(e.illegal));
    endtask

    // Monitor: outputs are presented every cycle; check each queued expectation.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            while (q0.size() > 0) compare(0, q0.pop_front());
            while (q1.size() > 0) compare(1, q1.pop_front());
        end
    end

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 8) == 8) ? ZR : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [10:0] low;
        int k, sh;
        k = $urandom_range(0, 19);
        w = $urandom;
        if (k < 16) begin
            sh  = 11 - tbl[k].plen;
            low = (11'd1 << sh) - 11'd1;
            w[31:21] = tbl[k].pat | (11'($urandom) & low);
        end else if (k == 16) begin
            w[31:21] = 11'd0;
        end
        w[4:0] = pick_reg(); w[9:5] = pick_reg(); w[20:16] = pick_reg();
        return w;
    endfunction

    function automatic logic [31:0] r_enc(input logic [10:0] op, input logic [4:0] rd,
                                          input logic [4:0] rn, input logic [4:0] rm);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    initial begin
        int drain;
        tbl[0]  = '{11, 11'b10001011000, F_R,    1, 1};
        tbl[1]  = '{11, 11'b11001011000, F_R,    1, 1};
        tbl[2]  = '{11, 11'b10001010000, F_R,    1, 1};
        tbl[3]  = '{11, 11'b10101010000, F_R,    1, 1};
        tbl[4]  = '{11, 11'b11001010000, F_R,    1, 1};
        tbl[5]  = '{10, 11'b10010001000, F_I,    1, 0};
        tbl[6]  = '{10, 11'b11010001000, F_I,    1, 0};
        tbl[7]  = '{11, 11'b11010011011, F_I,    1, 0};
        tbl[8]  = '{11, 11'b11010011010, F_I,    1, 0};
        tbl[9]  = '{11, 11'b11111000010, F_LD,   1, 0};
        tbl[10] = '{11, 11'b11111000000, F_ST,   1, 1};
        tbl[11] = '{11, 11'b11010110000, F_BR,   1, 0};
        tbl[12] = '{8,  11'b10110100000, F_CBZ,  0, 1};
        tbl[13] = '{8,  11'b10110101000, F_CBNZ, 0, 1};
        tbl[14] = '{6,  11'b10010100000, F_BL,   0, 0};
        tbl[15] = '{6,  11'b00010100000, F_B,    0, 0};
        for (int m = 0; m < 2; m++) begin
            m_ex[m] = bubble(); m_mem[m] = bubble(); m_wb[m] = bubble();
        end
        instr = '0; id_valid = 0; branch_taken = 0; ext_stall = 0; reset = 1;

        step(32'h0, 0, 0, 0, 1, 0);
        step(32'h0, 0, 0, 0, 1);
        // ADD X1,X2,X3 flowing through
        step(r_enc(11'b10001011000, 5'd1, 5'd2, 5'd3), 1, 0, 0, 0);
        idle(4);
        // load-use: LDUR X5,[X6]; SUB X7,X5,X8 (IF/ID held during the stall)
        step({11'b11111000010, 9'd0, 2'b00, 5'd6, 5'd5}, 1, 0, 0, 0);
        step(r_enc(11'b11001011000, 5'd7, 5'd5, 5'd8), 1, 0, 0, 0);
        step(r_enc(11'b11001011000, 5'd7, 5'd5, 5'd8), 1, 0, 0, 0);
        idle(4);
        // load into XZR never stalls
        step({11'b11111000010, 9'd0, 2'b00, 5'd6, 5'd31}, 1, 0, 0, 0);
        step(r_enc(11'b11001011000, 5'd7, 5'd31, 5'd8), 1, 0, 0, 0);
        idle(4);
        // CBNZ X9, two younger ADDs, branch resolves taken in MEM
        step({8'b10110101, 19'd4, 5'd9}, 1, 0, 0, 0);
        step(r_enc(11'b10001011000, 5'd1, 5'd2, 5'd3), 1, 0, 0, 0);
        step(r_enc(11'b10001011000, 5'd4, 5'd2, 5'd3), 1, 1, 0, 0);
        idle(4);
        // stall for three cycles, then a taken branch during the stall
        step(r_enc(11'b10001011000, 5'd2, 5'd1, 5'd3), 1, 0, 0, 0);
        step(r_enc(11'b10101010000, 5'd3, 5'd1, 5'd2), 1, 0, 1, 0);
        step(r_enc(11'b10101010000, 5'd3, 5'd1, 5'd2), 1, 0, 1, 0);
        step(r_enc(11'b10101010000, 5'd3, 5'd1, 5'd2), 1, 0, 1, 0);
        step(r_enc(11'b10101010000, 5'd3, 5'd1, 5'd2), 1, 1, 1, 0);
        idle(4);
        // BL, BR X3, opcode 0
        step({6'b100101, 26'd8}, 1, 0, 0, 0);
        step({11'b11010110000, 5'd31, 6'd0, 5'd3, 5'd0}, 1, 0, 0, 0);
        step(32'h0, 1, 0, 0, 0);
        idle(4);
        // reset while stalled
        step({11'b11111000010, 9'd0, 2'b00, 5'd6, 5'd5}, 1, 0, 0, 0);
        step(r_enc(11'b10001011000, 5'd1, 5'd2, 5'd3), 1, 0, 1, 0);
        step(r_enc(11'b10001011000, 5'd1, 5'd2, 5'd3), 1, 0, 1, 1);
        idle(2);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 127) == 0);
        end
        drain = 0;
        while ((q0.size() > 0 || q1.size() > 0) && drain < 5) begin
            @(negedge clock);
            #3;
            drain++;
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations still pending, required 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
